// File: rtl/cd_param_pkg.sv
// rtl/cd_param_pkg.sv - shared encodings, instruction field positions and flag indices for cd_param
package cd_param_pkg;

    typedef enum logic [2:0] {
        ALU_PASS_A = 3'b000,
        ALU_NOT_A  = 3'b001,
        ALU_ADD    = 3'b010,
        ALU_SUB    = 3'b011,
        ALU_AND    = 3'b100,
        ALU_OR     = 3'b101,
        ALU_NEG_A  = 3'b110,
        ALU_NEG_B  = 3'b111
    } alu_op_e;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RA1_LSB    = 22;
    localparam int RA2_LSB    = 18;
    localparam int WA3_LSB    = 14;
    localparam int IMM_W      = 16;
    localparam int REG_AW     = 4;
    localparam int NUM_REGS   = 16;

    localparam int FLAG_Z     = 0;
    localparam int FLAG_C     = 1;
    localparam int FLAG_N     = 2;
    localparam int NUM_FLAGS  = 3;

endpackage

// File: rtl/cd_stack.sv
// rtl/cd_stack.sv - parametrised return-address stack with empty status and sticky error
module cd_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         err
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   count;
    logic [AW-1:0] top_idx;
    logic          full;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign top_idx = AW'(count - (AW+1)'(1));
    assign top     = mem[top_idx];

    // Occupancy and sticky error; an illegal push/pop leaves the stack untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            err   <= 1'b0;
        end else if (push && pop) begin
            if (empty) begin
                err <= 1'b1;
            end
        end else if (push) begin
            if (full) begin
                err <= 1'b1;
            end else begin
                count <= count + (AW+1)'(1);
            end
        end else if (pop) begin
            if (empty) begin
                err <= 1'b1;
            end else begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    // Entry storage: push fills the next free slot, push+pop overwrites the top
    always_ff @(posedge clk) begin
        if (push && pop && !empty) begin
            mem[top_idx] <= din;
        end else if (push && !pop && !full) begin
            mem[count[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/cd_param.sv
// rtl/cd_param.sv - parametrised single-cycle datapath with return stack and interrupt entry
module cd_param
    import cd_param_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int DATA_W    = 16,
    parameter int STK_DEPTH = 8,
    parameter int IRQ_VEC   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_inc,
    input  logic              s_inm,
    input  logic              we3,
    input  logic              wez,
    input  logic              push,
    input  logic              pop,
    input  logic              s_pila,
    input  logic              s_datos,
    input  logic              oe,
    input  logic              reti,
    input  logic              ei,
    input  logic              di,
    input  logic [2:0]        op_alu,
    input  logic              irq,
    input  logic [31:0]       instr,
    output logic [PC_W-1:0]   pc,
    inout  wire  [DATA_W-1:0] datos,
    output logic [5:0]        opcode,
    output logic              z,
    output logic              c,
    output logic              n,
    output logic              int_ack,
    output logic              stk_err
);

    logic                 ie;
    logic                 int_entry;
    logic [PC_W-1:0]      pc_inc;
    logic [PC_W-1:0]      pc_next;
    logic [PC_W-1:0]      stk_top;
    logic [PC_W-1:0]      stk_din;
    logic                 stk_push;
    logic                 stk_pop;
    logic                 stk_empty;
    logic [REG_AW-1:0]    ra1;
    logic [REG_AW-1:0]    ra2;
    logic [REG_AW-1:0]    wa3;
    logic [DATA_W-1:0]    regs [NUM_REGS];
    logic [DATA_W-1:0]    r1;
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
    logic [DATA_W-1:0]    result;
    logic [DATA_W-1:0]    wdata;
    logic [DATA_W-1:0]    bus_in;
    logic [DATA_W:0]      wide;
    logic                 carry;
    logic [NUM_FLAGS-1:0] flags;
    logic                 reg_we;
    logic                 bus_oe;

    // An interrupt is taken only when enabled and not colliding with a return
    assign int_entry = irq & ie & ~reti;
    assign int_ack   = int_entry;

    assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
    assign ra1    = instr[RA1_LSB +: REG_AW];
    assign ra2    = instr[RA2_LSB +: REG_AW];
    assign wa3    = instr[WA3_LSB +: REG_AW];

    assign r1 = (ra1 == '0) ? '0 : regs[ra1];
    assign b  = (ra2 == '0) ? '0 : regs[ra2];
    assign a  = s_inm ? DATA_W'($signed(instr[IMM_W-1:0])) : r1;

    // Interrupt entry swallows every side effect of the interrupted instruction
    assign reg_we = we3 & ~int_entry & ~reset;
    assign bus_oe = oe & ~int_entry & ~reset;

    assign datos  = bus_oe ? r1 : {DATA_W{1'bz}};
    assign bus_in = datos;
    assign wdata  = s_datos ? bus_in : result;

    // Entry saves the current pc so the interrupted instruction runs again on return
    assign stk_push = int_entry | push;
    assign stk_pop  = ~int_entry & (pop | reti);
    assign stk_din  = int_entry ? pc : pc_inc;
    assign pc_inc   = pc + PC_W'(1);

    cd_stack #(
        .DEPTH (STK_DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (stk_din),
        .top   (stk_top),
        .empty (stk_empty),
        .err   (stk_err)
    );

    // ALU with carry/borrow taken from one extra bit
    always_comb begin
        result = '0;
        wide   = '0;
        carry  = 1'b0;
        case (alu_op_e'(op_alu))
            ALU_PASS_A: result = a;
            ALU_NOT_A:  result = ~a;
            ALU_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            ALU_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_NEG_A:  result = -a;
            ALU_NEG_B:  result = -b;
            default:    result = a;
        endcase
    end

    // Next pc: interrupt, then return, then stack, then increment, then jump target
    always_comb begin
        pc_next = instr[PC_W-1:0];
        if (int_entry) begin
            pc_next = PC_W'(IRQ_VEC);
        end else if (reti) begin
            pc_next = stk_empty ? '0 : stk_top;
        end else if (s_pila) begin
            pc_next = stk_top;
        end else if (s_inc) begin
            pc_next = pc_inc;
        end
    end

    // Program counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

    // Interrupt enable: entry clears it, di beats ei, reti re-enables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie <= 1'b0;
        end else if (int_entry || di) begin
            ie <= 1'b0;
        end else if (ei || reti) begin
            ie <= 1'b1;
        end
    end

    // Condition flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= '0;
        end else if (wez && !int_entry) begin
            flags[FLAG_Z] <= (result == '0);
            flags[FLAG_C] <= carry;
            flags[FLAG_N] <= result[DATA_W-1];
        end
    end

    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign n = flags[FLAG_N];

    // Register file keeps its contents across reset
    always_ff @(posedge clk) begin
        if (reg_we) begin
            regs[wa3] <= wdata;
        end
    end

endmodule

// File: tb/tb_cd_param.sv
// tb/tb_cd_param.sv - self-checking bench for cd_param with a queue-based reference model
module tb_cd_param;

    localparam int PC_W  = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 2;
    localparam int IVEC  = 9;

    logic clk = 1'b0;
    logic reset;
    logic s_inc, s_inm, we3, wez, push, pop, s_pila, s_datos, oe, reti, ei, di, irq;
    logic [2:0] op_alu;
    logic [31:0] instr;
    wire [PC_W-1:0] pc;
    wire [DW-1:0] datos;
    wire [5:0] opcode;
    wire z, c, n, int_ack, stk_err;
    logic tb_drive;
    logic [DW-1:0] tb_bus;

    int checks = 0;
    int errors = 0;

    assign datos = tb_drive ? tb_bus : {DW{1'bz}};

    cd_param #(.PC_W(PC_W), .DATA_W(DW), .STK_DEPTH(DEPTH), .IRQ_VEC(IVEC)) dut (
        .clk(clk), .reset(reset), .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez),
        .push(push), .pop(pop), .s_pila(s_pila), .s_datos(s_datos), .oe(oe),
        .reti(reti), .ei(ei), .di(di), .op_alu(op_alu), .irq(irq), .instr(instr),
        .pc(pc), .datos(datos), .opcode(opcode), .z(z), .c(c), .n(n),
        .int_ack(int_ack), .stk_err(stk_err)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mk(input int r1, input int r2, input int wr);
        logic [31:0] w;
        w = '0;
        w[25:22] = r1[3:0];
        w[21:18] = r2[3:0];
        w[17:14] = wr[3:0];
        return w;
    endfunction

    task automatic idle();
        s_inc = 0; s_inm = 0; we3 = 0; wez = 0; push = 0; pop = 0; s_pila = 0;
        s_datos = 0; oe = 0; reti = 0; ei = 0; di = 0; irq = 0; op_alu = 3'b000;
        instr = '0; tb_drive = 1; tb_bus = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic write_reg(input int r, input logic [DW-1:0] v);
        idle();
        instr = mk(0, 0, r);
        tb_bus = v; s_datos = 1; we3 = 1;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        step(); step();
        checks++; if (pc !== 4'd0) begin errors++; $display("FAIL reset_pc got %0h exp 0", pc); end
        checks++; if ({z, c, n} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {z, c, n}); end
        checks++; if (stk_err !== 1'b0) begin errors++; $display("FAIL reset_stk_err got %b exp 0", stk_err); end
        checks++; if (int_ack !== 1'b0) begin errors++; $display("FAIL reset_int_ack got %b exp 0", int_ack); end
        reset = 0;
        write_reg(1, 16'hA5A5);
        reset = 1;
        oe = 1; instr = mk(1, 0, 0); tb_drive = 1; tb_bus = 16'h5A5A;
        #1;
        checks++; if (datos !== 16'h5A5A) begin errors++; $display("FAIL reset_bus_released got %h exp 5a5a", datos); end
        step();
        idle();
        reset = 0;
    endtask

    task automatic test_pc_inc();
        do_reset();
        s_inc = 1;
        checks++; if (pc !== 4'd0) begin errors++; $display("FAIL inc_start got %0d exp 0", pc); end
        for (int i = 1; i <= 17; i++) begin
            step();
            checks++;
            if (pc !== 4'(i % 16)) begin errors++; $display("FAIL inc_pc step %0d got %0d exp %0d", i, pc, i % 16); end
        end
        idle();
    endtask

    task automatic test_alu_flags();
        do_reset();
        write_reg(1, 16'h7FFF);
        write_reg(2, 16'h0001);
        instr = mk(1, 2, 3); op_alu = 3'b010; wez = 1; we3 = 1;
        step(); idle();
        checks++; if ({z, c, n} !== 3'b001) begin errors++; $display("FAIL add_ovf_flags zcn got %b exp 001", {z, c, n}); end
        instr = mk(3, 0, 0); oe = 1; tb_drive = 0;
        #1;
        checks++; if (datos !== 16'h8000) begin errors++; $display("FAIL add_result got %h exp 8000", datos); end
        idle();
        instr = mk(2, 2, 0); op_alu = 3'b011; wez = 1;
        step(); idle();
        checks++; if ({z, c, n} !== 3'b100) begin errors++; $display("FAIL sub_equal zcn got %b exp 100", {z, c, n}); end
        write_reg(4, 16'hFFFF);
        instr = mk(4, 2, 0); op_alu = 3'b010; wez = 1;
        step(); idle();
        checks++; if ({z, c, n} !== 3'b110) begin errors++; $display("FAIL add_carry zcn got %b exp 110", {z, c, n}); end
        instr = mk(0, 2, 0); op_alu = 3'b011; wez = 1;
        step(); idle();
        checks++; if ({z, c, n} !== 3'b011) begin errors++; $display("FAIL sub_borrow zcn got %b exp 011", {z, c, n}); end
        instr = 32'h0000_8001; s_inm = 1; op_alu = 3'b000; wez = 1;
        step(); idle();
        checks++; if ({z, c, n} !== 3'b001) begin errors++; $display("FAIL imm_pass zcn got %b exp 001", {z, c, n}); end
    endtask

    task automatic test_data_bus();
        do_reset();
        write_reg(6, 16'hA5A5);
        instr = mk(6, 0, 0); oe = 1; tb_drive = 0;
        #1;
        checks++; if (datos !== 16'hA5A5) begin errors++; $display("FAIL bus_drive got %h exp a5a5", datos); end
        write_reg(7, 16'h1234);
        instr = mk(7, 0, 0); oe = 1; tb_drive = 0;
        #1;
        checks++; if (datos !== 16'h1234) begin errors++; $display("FAIL bus_capture got %h exp 1234", datos); end
        write_reg(0, 16'hFFFF);
        instr = mk(0, 0, 0); oe = 1; tb_drive = 0;
        #1;
        checks++; if (datos !== 16'h0000) begin errors++; $display("FAIL r0_zero got %h exp 0000", datos); end
        idle();
    endtask

    task automatic test_stack();
        do_reset();
        instr = 32'd3;
        step();
        checks++; if (pc !== 4'd3) begin errors++; $display("FAIL stk_setup_pc got %0d exp 3", pc); end
        s_inc = 1; push = 1;
        step(); step();
        checks++; if (stk_err !== 1'b0) begin errors++; $display("FAIL stk_two_push_err got %b exp 0", stk_err); end
        step();
        checks++; if (stk_err !== 1'b1) begin errors++; $display("FAIL stk_overflow_err got %b exp 1", stk_err); end
        push = 0; s_inc = 0; s_pila = 1; pop = 1;
        step();
        checks++; if (pc !== 4'd5) begin errors++; $display("FAIL stk_pop1 got %0d exp 5", pc); end
        step();
        checks++; if (pc !== 4'd4) begin errors++; $display("FAIL stk_pop2 got %0d exp 4", pc); end
        idle();
        do_reset();
        checks++; if (stk_err !== 1'b0) begin errors++; $display("FAIL stk_err_cleared got %b exp 0", stk_err); end
        pop = 1;
        step(); idle();
        checks++; if (stk_err !== 1'b1) begin errors++; $display("FAIL stk_underflow got %b exp 1", stk_err); end
        do_reset();
        instr = 32'd3;
        step();
        s_inc = 1; push = 1;
        step();
        pop = 1;
        step();
        checks++; if (stk_err !== 1'b0) begin errors++; $display("FAIL stk_replace_err got %b exp 0", stk_err); end
        push = 0; s_inc = 0; s_pila = 1; pop = 1;
        step();
        checks++; if (pc !== 4'd5) begin errors++; $display("FAIL stk_replace_top got %0d exp 5", pc); end
        s_pila = 0;
        step(); idle();
        checks++; if (stk_err !== 1'b1) begin errors++; $display("FAIL stk_replace_depth got %b exp 1", stk_err); end
    endtask

    task automatic test_interrupt();
        do_reset();
        write_reg(5, 16'h1111);
        ei = 1;
        step(); idle();
        instr = 32'd7;
        step();
        checks++; if (pc !== 4'd7) begin errors++; $display("FAIL irq_setup_pc got %0d exp 7", pc); end
        irq = 1; we3 = 1; s_datos = 1; tb_bus = 16'hBEEF; instr = mk(0, 0, 5) | 32'd7;
        wez = 1; op_alu = 3'b000; s_inc = 1; push = 1;
        #1;
        checks++; if (int_ack !== 1'b1) begin errors++; $display("FAIL irq_ack got %b exp 1", int_ack); end
        step();
        checks++; if (pc !== 4'(IVEC)) begin errors++; $display("FAIL irq_vector got %0d exp %0d", pc, IVEC); end
        checks++; if (int_ack !== 1'b0) begin errors++; $display("FAIL irq_ack_pulse got %b exp 0", int_ack); end
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL irq_wez_suppressed got z=%b exp 0", z); end
        idle();
        instr = mk(5, 0, 0); oe = 1; tb_drive = 0;
        #1;
        checks++; if (datos !== 16'h1111) begin errors++; $display("FAIL irq_we3_suppressed got %h exp 1111", datos); end
        idle();
        reti = 1;
        step(); idle();
        checks++; if (pc !== 4'd7) begin errors++; $display("FAIL reti_pc got %0d exp 7", pc); end
        irq = 1;
        #1;
        checks++; if (int_ack !== 1'b1) begin errors++; $display("FAIL reti_ie got int_ack=%b exp 1", int_ack); end
        idle();
        instr = 32'd3; push = 1;
        step(); step();
        checks++; if (stk_err !== 1'b0) begin errors++; $display("FAIL irq_fill_err got %b exp 0", stk_err); end
        idle();
        instr = 32'd3; irq = 1;
        #1;
        checks++; if (int_ack !== 1'b1) begin errors++; $display("FAIL irq_full_ack got %b exp 1", int_ack); end
        step(); idle();
        checks++; if (pc !== 4'(IVEC)) begin errors++; $display("FAIL irq_full_pc got %0d exp %0d", pc, IVEC); end
        checks++; if (stk_err !== 1'b1) begin errors++; $display("FAIL irq_full_err got %b exp 1", stk_err); end
        do_reset();
        instr = 32'd5;
        step(); idle();
        reti = 1;
        step(); idle();
        checks++; if (pc !== 4'd0) begin errors++; $display("FAIL reti_empty_pc got %0d exp 0", pc); end
        checks++; if (stk_err !== 1'b1) begin errors++; $display("FAIL reti_empty_err got %b exp 1", stk_err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        write_reg(1, 16'hFFFF);
        instr = mk(1, 0, 0); wez = 1; op_alu = 3'b000;
        step(); idle();
        pop = 1;
        step(); idle();
        ei = 1;
        step(); idle();
        instr = 32'd7;
        step();
        irq = 1; oe = 1; tb_drive = 1; tb_bus = 16'h5A5A;
        #1;
        checks++; if ({int_ack, n, stk_err, pc} !== {3'b111, 4'd7}) begin
            errors++; $display("FAIL arst_pre got ack/n/err/pc %b%b%b/%0d exp 111/7", int_ack, n, stk_err, pc);
        end
        #1 reset = 1;
        #1;
        checks++; if (pc !== 4'd0) begin errors++; $display("FAIL arst_pc got %0d exp 0", pc); end
        checks++; if ({z, c, n} !== 3'b000) begin errors++; $display("FAIL arst_flags got %b exp 000", {z, c, n}); end
        checks++; if (stk_err !== 1'b0) begin errors++; $display("FAIL arst_err got %b exp 0", stk_err); end
        checks++; if (int_ack !== 1'b0) begin errors++; $display("FAIL arst_ack got %b exp 0", int_ack); end
        checks++; if (datos !== 16'h5A5A) begin errors++; $display("FAIL arst_bus got %h exp 5a5a", datos); end
        step();
        idle();
        reset = 0;
    endtask

    task automatic test_random();
        logic [15:0] mregs [16];
        int q[$];
        int mpc, npc, top, av, bv, r1v, res, t, ra1, ra2, wa;
        bit mz, mc, mn, mie, merr, entry, cy, popq;
        for (int r = 1; r < 16; r++) begin
            mregs[r] = 16'($urandom);
            write_reg(r, mregs[r]);
        end
        mregs[0] = '0;
        do_reset();
        mpc = 0; q.delete(); mz = 0; mc = 0; mn = 0; mie = 0; merr = 0;
        for (int it = 0; it < 400; it++) begin
            idle();
            instr = $urandom; op_alu = 3'($urandom);
            s_inm = 1'($urandom); wez = 1'($urandom); we3 = 1'($urandom);
            s_datos = 1'($urandom); s_inc = 1'($urandom);
            irq = ($urandom % 4 == 0); ei = ($urandom % 6 == 0); di = ($urandom % 12 == 0);
            push = ($urandom % 4 == 0); pop = ($urandom % 4 == 0);
            if (push && pop && q.size() == 0) pop = 0;
            s_pila = (q.size() > 0) && ($urandom % 6 == 0);
            reti = !push && !pop && !di && ($urandom % 8 == 0);
            oe = ($urandom % 3 == 0); tb_drive = !oe; tb_bus = 16'($urandom);
            #1;
            ra1 = int'(instr[25:22]); ra2 = int'(instr[21:18]); wa = int'(instr[17:14]);
            r1v = (ra1 == 0) ? 0 : int'(mregs[ra1]);
            bv  = (ra2 == 0) ? 0 : int'(mregs[ra2]);
            av  = s_inm ? int'(instr[15:0]) : r1v;
            entry = irq && mie && !reti;
            cy = 0;
            case (op_alu)
                3'd0: res = av;
                3'd1: res = 65535 - av;
                3'd2: begin t = av + bv; res = t % 65536; cy = (t > 65535); end
                3'd3: begin res = (av - bv + 65536) % 65536; cy = (av < bv); end
                3'd4: res = av & bv;
                3'd5: res = av | bv;
                3'd6: res = (65536 - av) % 65536;
                default: res = (65536 - bv) % 65536;
            endcase
            checks++; if (int_ack !== entry) begin errors++; $display("FAIL rnd_int_ack it=%0d got %b exp %b", it, int_ack, entry); end
            checks++; if (opcode !== instr[31:26]) begin errors++; $display("FAIL rnd_opcode it=%0d got %h exp %h", it, opcode, instr[31:26]); end
            if (oe && !entry) begin
                checks++; if (datos !== 16'(r1v)) begin errors++; $display("FAIL rnd_bus it=%0d got %h exp %h", it, datos, 16'(r1v)); end
            end
            top = (q.size() > 0) ? q[$] : 0;
            if (entry) npc = IVEC;
            else if (reti) npc = top;
            else if (s_pila) npc = top;
            else if (s_inc) npc = (mpc + 1) % 16;
            else npc = int'(instr[3:0]);
            if (entry) begin
                if (q.size() == DEPTH) merr = 1; else q.push_back(mpc);
            end else begin
                popq = pop || reti;
                if (push && popq) begin
                    if (q.size() == 0) merr = 1; else q[$] = (mpc + 1) % 16;
                end else if (push) begin
                    if (q.size() == DEPTH) merr = 1; else q.push_back((mpc + 1) % 16);
                end else if (popq) begin
                    if (q.size() == 0) merr = 1; else void'(q.pop_back());
                end
                if (wez) begin mz = (res == 0); mc = cy; mn = (res >= 32768); end
                if (we3 && wa != 0) mregs[wa] = s_datos ? (oe ? 16'(r1v) : tb_bus) : 16'(res);
            end
            if (entry || di) mie = 0;
            else if (ei || reti) mie = 1;
            mpc = npc;
            step();
            checks++; if (pc !== 4'(mpc)) begin errors++; $display("FAIL rnd_pc it=%0d got %0d exp %0d", it, pc, mpc); end
            checks++; if ({z, c, n} !== {mz, mc, mn}) begin errors++; $display("FAIL rnd_flags it=%0d got %b exp %b", it, {z, c, n}, {mz, mc, mn}); end
            checks++; if (stk_err !== merr) begin errors++; $display("FAIL rnd_stk_err it=%0d got %b exp %b", it, stk_err, merr); end
        end
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_pc_inc();
        test_alu_flags();
        test_data_bus();
        test_stack();
        test_interrupt();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
